// File: rtl/adder_tree_feeder.sv
// Serial-to-parallel packer feeding adder_tree: collects one element per cycle into a
// fill buffer and hands completed (zero-padded) vectors to a held output register.
//
// state  | meaning
// S_FILL | accepting elements into the fill buffer
// S_WAIT | fill buffer holds a completed vector, output register still occupied
module adder_tree_feeder #(
    parameter int DATAWIDTH  = 4,
    parameter int NUM_INPUTS = 16,
    localparam int CW = $clog2(NUM_INPUTS + 1),
    localparam int LW = $clog2(NUM_INPUTS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [DATAWIDTH-1:0]                  s_data,
    input  logic                                  s_last,
    output logic                                  o_valid,
    input  logic                                  o_ready,
    output logic [NUM_INPUTS-1:0][DATAWIDTH-1:0]  o_data,
    output logic [CW-1:0]                         o_count
);

    typedef enum logic {S_FILL, S_WAIT} state_t;

    state_t                               state, state_d;
    logic                                 rdy_en;
    logic [CW-1:0]                        cnt;
    logic [NUM_INPUTS-1:0][DATAWIDTH-1:0] fill, fill_next;
    logic                                 accept, complete, out_free;

    assign s_ready  = rdy_en && (state == S_FILL);
    assign accept   = s_valid && s_ready;
    assign complete = accept && ((cnt == CW'(NUM_INPUTS - 1)) || s_last);
    assign out_free = !o_valid || o_ready;

    // Lanes above the written one are already zero because fill is cleared per vector.
    always_comb begin
        fill_next = fill;
        fill_next[cnt[LW-1:0]] = s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FILL;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_FILL:  if (complete && !out_free) state_d = S_WAIT;
            S_WAIT:  if (o_ready)               state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en  <= 1'b0;
            cnt     <= '0;
            fill    <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_count <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (o_valid && o_ready) o_valid <= 1'b0;
            if (state == S_WAIT) begin
                // In WAIT cnt already holds the completed lane count.
                if (o_ready) begin
                    o_data  <= fill;
                    o_count <= cnt;
                    o_valid <= 1'b1;
                    fill    <= '0;
                    cnt     <= '0;
                end
            end else if (complete) begin
                if (out_free) begin
                    o_data  <= fill_next;
                    o_count <= cnt + CW'(1);
                    o_valid <= 1'b1;
                    fill    <= '0;
                    cnt     <= '0;
                end else begin
                    fill <= fill_next;
                    cnt  <= cnt + CW'(1);
                end
            end else if (accept) begin
                fill <= fill_next;
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule
